qspi_ram_responder: RTL and testbench
=====================================

# qspi_ram_responder

Behavioural responder for the QSPI RAM bus that `main` drives as initiator. The bus signals are `ram_clk`, `ram_csn`, `ram_bank[1:0]` and `ram_io0..3`. The block emulates one quad-mode PSRAM bank backed by an internal byte array, so a design can be exercised on-board or in simulation without an external chip. It oversamples the initiator's bus on the local `clock`, decodes command, address, dummy and data phases, and drives read data back on the tristate nibble.

## Interface
Parameters:
- `ADDR_W`, 12: memory depth is 2^ADDR_W bytes. Address bits above ADDR_W-1 are ignored, so addresses wrap.
- `DUMMY`, 6: number of `ram_clk` rising edges between the last address nibble and the first read nibble.
- `BANK`, 0: the value of `ram_bank` this instance answers to.

Ports:
- `clock` in 1: system clock. Its frequency must be at least 8× the `ram_clk` frequency.
- `reset` in 1: asynchronous, active-low. Asserting it clears all state.
- `ram_clk` in 1: bus clock from the initiator.
- `ram_csn` in 1: chip select from the initiator, active-low.
- `ram_bank` in 2: bank select from the initiator.
- `ram_io_i` in 4: bus nibble as seen at the pads. Bit *n* is `ram_io`*n*.
- `ram_io_o` out 4: nibble this block drives.
- `ram_io_oe` out 1: output enable, applied to all four io bits.
- `bd_we` in 1: backdoor write strobe, for preload.
- `bd_addr` in ADDR_W: backdoor address.
- `bd_data` in 8: backdoor write data.
- `bd_q` out 8: backdoor read data, registered. It presents `mem[bd_addr]` one cycle after the address is applied.
- `busy` out 1: high while a transaction is selected.

## Operation
- **Input synchronisation.** `ram_clk`, `ram_csn`, `ram_bank` and `ram_io_i` each pass through a 2-flop synchroniser. All io paths have the same depth so they stay aligned.
  - A rising edge is `clk_s1 & ~clk_s2`; a falling edge is the inverse.
- **Nibble order.** All phases are 4 bits wide, starting from the first rising edge after select. Within each byte the high nibble comes first.
- **State machine.** States are IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE → CMD: synced `ram_csn` falls.
    - Goes to IGNORE instead if synced `ram_bank` ≠ `BANK`; `ram_bank` is sampled at this moment.
  - CMD: collect 2 nibbles.
    - 0xEB → ADDR, with read flag set.
    - 0x38 → ADDR, with write flag set.
    - Any other value → IGNORE.
  - ADDR: collect 6 nibbles, MSB first, into a 24-bit register. Only the low ADDR_W bits are used.
    - After the 6th nibble: read goes to DUMMY; write goes to WDATA.
    - On entering DUMMY, issue the memory read of `mem[addr]`.
  - DUMMY: count `DUMMY` rising edges, then → RDATA.
    - Assert `ram_io_oe` on the falling edge that follows the last dummy rising edge.
    - Present the high nibble of the fetched byte at that same edge.
  - RDATA: on each falling edge, advance the output nibble.
    - After a low nibble, increment the address modulo 2^ADDR_W and prefetch the next byte.
  - WDATA: on each rising edge, capture a nibble.
    - On the low nibble, write `mem[addr]` and increment the address with the same wrap rule.
    - A lone high nibble at deselect is discarded.
  - IGNORE: hold until deselect. `ram_io_oe` stays 0.
  - Any state → IDLE: synced `ram_csn` goes high. `ram_io_oe` drops on the next cycle. Nibble counters reset.
- **Backdoor.** The backdoor port is a second port on the array.
  - If a backdoor write and a bus write hit the same cycle, the bus write wins.
- **Outputs.** `busy` = (state ≠ IDLE).

## Timing
- **Reset values.** `ram_io_oe`=0, `ram_io_o`=0, `busy`=0, `bd_q`=0, state IDLE. Memory contents are not reset.
- **Edge detection latency.** A bus edge is detected 2–3 `clock` cycles after it occurs at the pin.
- **Read output timing.** `ram_io_o` and `ram_io_oe` update 1 cycle after falling-edge detection.
  - Total pin-to-pin delay is ≤4 `clock` cycles after the initiator's falling edge.
  - This is valid before the next rising edge, provided each `ram_clk` phase lasts ≥4 `clock` cycles.
- **Memory read latency.** 1 cycle. The prefetch completes before the next falling edge.
- **Read latency seen by the initiator.** Data nibble 0 is sampled on rising edge number 8 + DUMMY + 1 after select.
- **Deselect.** A deselect in any phase aborts cleanly. The next select starts at CMD.
- **Reset during a transaction.** Asserting `reset` immediately forces IDLE with `oe`=0. Bytes already committed by a write remain in memory.

## Test plan
- **Backdoor preload and quad read.** Preload `mem[0x010..0x013]` = 0xA1,0xB2,0xC3,0xD4. Issue 0xEB with address 0x000010 and 6 dummy edges. Read 8 nibbles → A,1,B,2,C,3,D,4. `oe` is high only during the data phase.
- **Quad write, then backdoor check.** Issue 0x38 with address 0x000100 and data 0x5A,0x3C. Then `bd_q`@0x100 = 0x5A and `bd_q`@0x101 = 0x3C.
- **Address wrap.** Write 0x77 at address 0xFFF and keep clocking to write 0x88. With ADDR_W=12, `mem[0x000]` = 0x88.
- **Bank mismatch and unknown command.** First transaction: `ram_bank`=1 with BANK=0. Second transaction: command 0x9F. In both cases `oe` stays 0 for the whole transaction, memory is unchanged, and `busy` falls after `csn` rises.
- **Abort mid-read.** Deselect after 3 data nibbles → `oe`=0 within 4 cycles. A following 0xEB read at 0x010 returns 0xA1 correctly.
- **Asynchronous reset mid-write.** Pulse `reset` low during WDATA → `oe`=0 and `busy`=0 immediately. Bytes completed before the reset remain readable through the backdoor.

Source files
------------

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: quad-mode PSRAM bank emulator.
// Oversamples the QSPI bus and serves reads/writes from a local array.
module qspi_ram_responder #(
  parameter int         ADDR_W = 12,
  parameter int         DUMMY  = 6,
  parameter logic [1:0] BANK   = 2'd0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ram_clk,
  input  logic              ram_csn,
  input  logic [1:0]        ram_bank,
  input  logic [3:0]        ram_io_i,
  output logic [3:0]        ram_io_o,
  output logic              ram_io_oe,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_data,
  output logic [7:0]        bd_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  logic       clk_m_q, clk_s1_q, clk_s2_q;
  logic       csn_m_q, csn_s1_q;
  logic [1:0] bank_m_q, bank_s1_q;
  logic [3:0] io_m_q, io_s1_q;

  state_t      state_q, state_d;
  logic [2:0]  nib_q, nib_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        rd_q, rd_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic        lo_q, lo_d;
  logic [3:0]  whi_q, whi_d;
  logic        oe_q, oe_d;
  logic [3:0]  out_q, out_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  bdq_q, bdq_d;

  logic              rise, fall;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] maddr;

  assign rise  = clk_s1_q & ~clk_s2_q;
  assign fall  = ~clk_s1_q & clk_s2_q;
  assign maddr = addr_q[ADDR_W-1:0];

  // Equal-depth synchronisers keep clock, select and data aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_m_q   <= 1'b0;
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      csn_m_q   <= 1'b1;
      csn_s1_q  <= 1'b1;
      bank_m_q  <= 2'd0;
      bank_s1_q <= 2'd0;
      io_m_q    <= 4'd0;
      io_s1_q   <= 4'd0;
    end else begin
      clk_m_q   <= ram_clk;
      clk_s1_q  <= clk_m_q;
      clk_s2_q  <= clk_s1_q;
      csn_m_q   <= ram_csn;
      csn_s1_q  <= csn_m_q;
      bank_m_q  <= ram_bank;
      bank_s1_q <= bank_m_q;
      io_m_q    <= ram_io_i;
      io_s1_q   <= io_m_q;
    end
  end

  // Bus protocol decode and next-state/output computation.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    dcnt_d  = dcnt_q;
    lo_d    = lo_q;
    whi_d   = whi_q;
    oe_d    = oe_q;
    out_d   = out_q;
    wr_en   = 1'b0;
    wr_data = {whi_q, io_s1_q};
    rdata_d = mem_q[maddr];
    bdq_d   = mem_q[bd_addr];
    if (state_q != S_IDLE && csn_s1_q) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      out_d   = 4'd0;
      nib_d   = 3'd0;
      lo_d    = 1'b0;
      dcnt_d  = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!csn_s1_q) begin
            state_d = (bank_s1_q == BANK) ? S_CMD : S_IGNORE;
            nib_d   = 3'd0;
            lo_d    = 1'b0;
            dcnt_d  = 8'd0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_d = io_s1_q;
            nib_d = nib_q + 3'd1;
            if (nib_q == 3'd1) begin
              nib_d = 3'd0;
              unique case ({cmd_q, io_s1_q})
                8'hEB: begin
                  state_d = S_ADDR;
                  rd_d    = 1'b1;
                end
                8'h38: begin
                  state_d = S_ADDR;
                  rd_d    = 1'b0;
                end
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            addr_d = {addr_q[19:0], io_s1_q};
            nib_d  = nib_q + 3'd1;
            if (nib_q == 3'd5) begin
              nib_d   = 3'd0;
              dcnt_d  = 8'd0;
              lo_d    = 1'b0;
              state_d = rd_q ? S_DUMMY : S_WDATA;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            dcnt_d = dcnt_q + 8'd1;
          end else if (fall && dcnt_q == 8'(DUMMY)) begin
            state_d = S_RDATA;
            oe_d    = 1'b1;
            out_d   = rdata_q[7:4];
            lo_d    = 1'b1;
          end
        end
        S_RDATA: begin
          if (fall) begin
            if (lo_q) begin
              out_d  = rdata_q[3:0];
              addr_d = addr_q + 24'd1;
              lo_d   = 1'b0;
            end else begin
              out_d = rdata_q[7:4];
              lo_d  = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (rise) begin
            if (!lo_q) begin
              whi_d = io_s1_q;
              lo_d  = 1'b1;
            end else begin
              wr_en  = 1'b1;
              addr_d = addr_q + 24'd1;
              lo_d   = 1'b0;
            end
          end
        end
        S_IGNORE: begin
          oe_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Protocol state and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nib_q   <= 3'd0;
      cmd_q   <= 4'd0;
      rd_q    <= 1'b0;
      addr_q  <= 24'd0;
      dcnt_q  <= 8'd0;
      lo_q    <= 1'b0;
      whi_q   <= 4'd0;
      oe_q    <= 1'b0;
      out_q   <= 4'd0;
      rdata_q <= 8'd0;
      bdq_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      cmd_q   <= cmd_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      dcnt_q  <= dcnt_d;
      lo_q    <= lo_d;
      whi_q   <= whi_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
      bdq_q   <= bdq_d;
    end
  end

  // Array write port; a bus write takes priority over the backdoor.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[maddr] <= wr_data;
    end else if (bd_we) begin
      mem_q[bd_addr] <= bd_data;
    end
  end

  assign ram_io_o  = out_q;
  assign ram_io_oe = oe_q;
  assign bd_q      = bdq_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: directed bench acting as QSPI initiator.
// Read nibbles are checked against a scoreboard queue.
module tb_qspi_ram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ram_clk = 1'b0;
  logic        ram_csn = 1'b1;
  logic [1:0]  ram_bank = 2'd0;
  logic [3:0]  tb_io = 4'd0;
  logic [3:0]  ram_io_i;
  logic [3:0]  ram_io_o;
  logic        ram_io_oe;
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = 12'd0;
  logic [7:0]  bd_data = 8'd0;
  logic [7:0]  bd_q;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] wnib_q[$];

  assign ram_io_i = ram_io_oe ? ram_io_o : tb_io;

  always #5 clock = ~clock;

  qspi_ram_responder #(
    .ADDR_W(12),
    .DUMMY(6),
    .BANK(2'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ram_clk(ram_clk),
    .ram_csn(ram_csn),
    .ram_bank(ram_bank),
    .ram_io_i(ram_io_i),
    .ram_io_o(ram_io_o),
    .ram_io_oe(ram_io_oe),
    .bd_we(bd_we),
    .bd_addr(bd_addr),
    .bd_data(bd_data),
    .bd_q(bd_q),
    .busy(busy)
  );

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we = 1'b1;
    wait_n(1);
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag,
                          input logic [11:0] a,
                          input logic [7:0] d);
    bd_addr = a;
    wait_n(2);
    chk(tag, bd_q, d);
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b[7:4]);
    exp_q.push_back(b[3:0]);
  endtask

  task automatic push_wr(input logic [7:0] b);
    wnib_q.push_back(b[7:4]);
    wnib_q.push_back(b[3:0]);
  endtask

  task automatic tick(input logic [3:0] nib,
                      output logic [3:0] r,
                      output logic o);
    tb_io = nib;
    wait_n(8);
    ram_clk = 1'b1;
    r = ram_io_i;
    o = ram_io_oe;
    wait_n(8);
    ram_clk = 1'b0;
  endtask

  task automatic start(input logic [1:0] bank);
    ram_bank = bank;
    ram_csn = 1'b0;
    wait_n(8);
  endtask

  task automatic stop();
    chk("busy_sel", busy, 1'b1);
    ram_csn = 1'b1;
    wait_n(4);
    chk("oe_desel", ram_io_oe, 1'b0);
    chk("busy_desel", busy, 1'b0);
    wait_n(8);
  endtask

  task automatic xfer(input logic [1:0] bank,
                      input logic [7:0] cmd,
                      input logic [23:0] addr,
                      input int ndata,
                      input bit rd);
    logic [3:0] r;
    logic o;
    logic [3:0] n;
    logic [3:0] e;
    start(bank);
    for (int i = 0; i < 2; i++) begin
      tick(4'(cmd >> (4 * (1 - i))), r, o);
      chk("oe_cmd", o, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      tick(4'(addr >> (4 * (5 - i))), r, o);
      chk("oe_addr", o, 1'b0);
    end
    if (rd) begin
      for (int i = 0; i < 6; i++) begin
        tick(4'd0, r, o);
        chk("oe_dummy", o, 1'b0);
      end
    end
    for (int i = 0; i < ndata; i++) begin
      if (rd) begin
        tick(4'd0, r, o);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        chk("oe_rdata", o, 1'b1);
        chk("rdata", r, e);
      end else begin
        n = (wnib_q.size() > 0) ? wnib_q.pop_front() : 4'd0;
        tick(n, r, o);
        chk("oe_wdata", o, 1'b0);
      end
    end
    stop();
  endtask

  initial begin
    logic [3:0] r;
    logic o;

    wait_n(3);
    chk("rst_oe", ram_io_oe, 1'b0);
    chk("rst_io_o", ram_io_o, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bd_q", bd_q, 8'd0);
    reset = 1'b1;
    wait_n(4);

    bd_write(12'h010, 8'hA1);
    bd_write(12'h011, 8'hB2);
    bd_write(12'h012, 8'hC3);
    bd_write(12'h013, 8'hD4);
    bd_write(12'h200, 8'hEE);
    bd_write(12'h302, 8'h66);
    bd_check("bd_pre", 12'h012, 8'hC3);

    push_exp(8'hA1);
    push_exp(8'hB2);
    push_exp(8'hC3);
    push_exp(8'hD4);
    xfer(2'd0, 8'hEB, 24'h000010, 8, 1'b1);

    push_wr(8'h5A);
    push_wr(8'h3C);
    xfer(2'd0, 8'h38, 24'h000100, 4, 1'b0);
    bd_check("wr_100", 12'h100, 8'h5A);
    bd_check("wr_101", 12'h101, 8'h3C);

    push_wr(8'h77);
    push_wr(8'h88);
    xfer(2'd0, 8'h38, 24'h000FFF, 4, 1'b0);
    bd_check("wrap_fff", 12'hFFF, 8'h77);
    bd_check("wrap_000", 12'h000, 8'h88);

    push_exp(8'h5A);
    push_exp(8'h3C);
    xfer(2'd0, 8'hEB, 24'hABC100, 4, 1'b1);

    push_wr(8'h11);
    push_wr(8'h22);
    xfer(2'd1, 8'h38, 24'h000200, 4, 1'b0);
    bd_check("bank_mem", 12'h200, 8'hEE);

    push_wr(8'h33);
    push_wr(8'h44);
    xfer(2'd0, 8'h9F, 24'h000200, 4, 1'b0);
    bd_check("cmd9f_mem", 12'h200, 8'hEE);

    push_exp(8'hA1);
    exp_q.push_back(4'hB);
    xfer(2'd0, 8'hEB, 24'h000010, 3, 1'b1);

    push_exp(8'hA1);
    xfer(2'd0, 8'hEB, 24'h000010, 2, 1'b1);

    start(2'd0);
    tick(4'h3, r, o);
    tick(4'h8, r, o);
    for (int i = 0; i < 6; i++) begin
      tick(4'(24'h000300 >> (4 * (5 - i))), r, o);
    end
    tick(4'h1, r, o);
    tick(4'h2, r, o);
    tick(4'h3, r, o);
    tick(4'h4, r, o);
    tick(4'h5, r, o);
    chk("busy_wdata", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst_mid_oe", ram_io_oe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    ram_csn = 1'b1;
    wait_n(4);
    reset = 1'b1;
    wait_n(8);
    bd_check("rst_300", 12'h300, 8'h12);
    bd_check("rst_301", 12'h301, 8'h34);
    bd_check("rst_302", 12'h302, 8'h66);

    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
